vector_read_streamer: RTL

- Read-side initiator for a per-lane banked vector memory.
- Accepts a strided load command (base, stride, count, lane mask) and issues one vector read per cycle to all enabled lanes.
- Tracks the fixed memory read latency and captures returned vectors into an internal FIFO.
- Streams the vectors to the SIMD datapath over a valid/ready interface.

---
 rtl/vector_read_streamer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vector_read_streamer.sv
// vector_read_streamer: strided vector load initiator with latency-tracked, credit-limited return FIFO.
// Define VMEM_RD_PERF_EN to add backpressure / credit-stall performance counters.
module vector_read_streamer #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int NUM_ELEM       = 64,
   parameter int READ_LATENCY_B = 1,
   parameter int COUNT_WIDTH    = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ADDR_WIDTH-1:0]          cmd_base_addr,
   input  logic [ADDR_WIDTH-1:0]          cmd_stride,
   input  logic [COUNT_WIDTH-1:0]         cmd_count,
   input  logic [NUM_ELEM-1:0]            cmd_lane_mask,
   output logic [NUM_ELEM-1:0]            mem_read_req,
   output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_read_addr,
   input  logic [DATA_WIDTH*NUM_ELEM-1:0] mem_read_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH*NUM_ELEM-1:0] out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
`ifdef VMEM_RD_PERF_EN
   ,
   output logic [31:0]                    perf_backpressure_cycles,
   output logic [31:0]                    perf_credit_stall_cycles
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] cur_addr, stride;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [NUM_ELEM-1:0] lane_mask;
   logic [READ_LATENCY_B-1:0] pipe_v, pipe_l;
   logic [CW-1:0] inflight, fifo_count;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH*NUM_ELEM-1:0] fifo_data [FIFO_DEPTH];
   logic fifo_last [FIFO_DEPTH];
   logic [DATA_WIDTH*NUM_ELEM-1:0] masked;
   logic accept, credit, issue, last_issue, push, pop, fin;

   // Credit counts reads still in the latency pipe so every return has a FIFO slot.
   assign credit = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
   assign accept = cmd_valid && cmd_ready;
   assign issue = state == ISSUE && credit;
   assign last_issue = remaining == COUNT_WIDTH'(1);
   assign push = pipe_v[READ_LATENCY_B-1];
   assign pop = out_valid && out_ready;
   assign fin = state == DRAIN && pop && out_last;
   assign cmd_ready = state == IDLE;
   assign busy = state != IDLE;
   assign out_valid = fifo_count != '0;
   assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_last = out_valid && fifo_last[rd_ptr];
   assign mem_read_req = issue ? lane_mask : '0;
   assign mem_read_addr = issue ? {NUM_ELEM{cur_addr}} : '0;

   for (genvar l = 0; l < NUM_ELEM; l++) begin : g_mask
      assign masked[l*DATA_WIDTH +: DATA_WIDTH] = lane_mask[l] ? mem_read_data[l*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   always_comb begin
      state_nx = state;
      if (state == IDLE && accept && cmd_count != '0) state_nx = ISSUE;
      if (issue && last_issue) state_nx = DRAIN;
      if (fin) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cur_addr <= '0;
         stride <= '0;
         remaining <= '0;
         lane_mask <= '0;
         pipe_v <= '0;
         pipe_l <= '0;
         inflight <= '0;
         fifo_count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         done <= 1'b0;
      end else begin
         state <= state_nx;
         done <= fin || (accept && cmd_count == '0);
         if (accept) begin
            cur_addr <= cmd_base_addr;
            stride <= cmd_stride;
            remaining <= cmd_count;
            lane_mask <= cmd_lane_mask;
         end else if (issue) begin
            cur_addr <= cur_addr + stride;
            remaining <= remaining - COUNT_WIDTH'(1);
         end
         pipe_v[0] <= issue;
         pipe_l[0] <= issue && last_issue;
         for (int i = 1; i < READ_LATENCY_B; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
         inflight <= inflight + CW'(issue) - CW'(push);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= masked;
         fifo_last[wr_ptr] <= pipe_l[READ_LATENCY_B-1];
      end
   end

`ifdef VMEM_RD_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_backpressure_cycles <= '0;
         perf_credit_stall_cycles <= '0;
      end else if (accept) begin
         perf_backpressure_cycles <= '0;
         perf_credit_stall_cycles <= '0;
      end else begin
         if (out_valid && !out_ready && perf_backpressure_cycles != '1)
            perf_backpressure_cycles <= perf_backpressure_cycles + 32'd1;
         if (state == ISSUE && !credit && perf_credit_stall_cycles != '1)
            perf_credit_stall_cycles <= perf_credit_stall_cycles + 32'd1;
      end
   end
`endif
endmodule
